fixed_point_divider: RTL and testbench
======================================

Name: fixed_point_divider

Overview:
- Sequential signed fixed-point divider: returns operand_1 / operand_2 in the same Q(WIDTH-FBITS).FBITS two's-complement format used by the fixed-point unit's add/sub/mul/sqrt paths.
- It is the inverse operation of the FPU multiplier. It slots in as an additional FPU operation, with a start/ready handshake compatible with the existing ready-driven FPU result mux.
- Implements a radix-2 restoring divider on magnitudes, one quotient bit per clock, then applies sign, saturation and status.

Parameters:
WIDTH  32  operand/result width in bits
FBITS  10  fractional bits (1.0 = 1 << FBITS)

Ports:
clk            input   1      clock, rising edge
reset          input   1      asynchronous, active-high reset
start          input   1      request; sampled only in IDLE
dividend       input   WIDTH  signed fixed-point numerator
divisor        input   WIDTH  signed fixed-point denominator
quotient       output  WIDTH  signed fixed-point result, truncated toward zero
remainder      output  WIDTH  remainder of (|dividend| << FBITS) / |divisor|, sign of dividend
busy           output  1      high while a division is in progress
ready          output  1      result valid; held until next accepted start
div_by_zero    output  1      last result came from divisor == 0
overflow       output  1      last quotient saturated (|q| out of range)

Behaviour:
- Reset (async, any state, including mid-division):
  - State -> IDLE.
  - quotient, remainder = 0; busy, ready, div_by_zero, overflow = 0.
  - Iteration counter cleared.
- Definitions:
  - N = WIDTH + FBITS (42 by default).
  - Internal numerator register holds |dividend| << FBITS (N bits).
  - Partial remainder is WIDTH+1 bits.
  - Iteration counter is ceil(log2(N)) bits.
- States: IDLE, CALC, SIGN.
- IDLE:
  - On start = 1 at edge k: latch signs and magnitudes; ready, div_by_zero and overflow -> 0.
  - Magnitude of the most-negative value is 2^(WIDTH-1), unsigned, with no wrap.
  - If divisor == 0: go directly to SIGN with the div_by_zero flag set; no CALC.
  - Otherwise go to CALC: busy = 1, counter = 0, partial remainder = 0.
- CALC, one iteration per edge:
  - Shift the next numerator MSB into the partial remainder.
  - Trial subtract |divisor|. If non-negative, keep the difference and shift quotient bit 1; otherwise restore and shift 0.
  - After exactly N iterations (edges k+1..k+N), go to SIGN.
- SIGN, one edge:
  - Negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
  - Positive quotients saturate to 2^(WIDTH-1)-1 if the magnitude exceeds it. Negative quotients saturate to -2^(WIDTH-1) if the magnitude exceeds 2^(WIDTH-1). Either case sets overflow = 1.
  - Divide by zero: quotient = 0x7FFF_FFFF if dividend >= 0, else 0x8000_0000; remainder = 0; div_by_zero = 1; overflow = 0.
  - Register the outputs, set ready = 1 and busy = 0, return to IDLE.
- Latency:
  - Normal: ready rises after edge k+N+1 (43 cycles).
  - Divide by zero: ready rises after edge k+1.
- Handshake:
  - start while busy is ignored: no restart and no corruption.
  - start in IDLE with ready = 1 clears ready at the same edge and begins the new operation.
  - Outputs are stable for the whole time ready = 1.
  - dividend and divisor may change after the start edge.
- Arithmetic:
  - Truncation toward zero.
  - Dividend 0 yields quotient 0, remainder 0, no flags.

Test Plan:
- 6.0/2.0: dividend=0x0000_1800, divisor=0x0000_0800, start 1 cycle -> ready exactly 43 cycles later; quotient=0x0000_0C00, remainder=0, flags 0; busy high for cycles 1..42.
- -7.5/2.0: 0xFFFF_E200 / 0x0000_0800 -> quotient=0xFFFF_F100 (-3.75), remainder=0, flags 0; also check 7.5/-2.0 and -7.5/-2.0 give 0xFFFF_F100 and 0x0000_0F00.
- 1.0/3.0: 0x0000_0400 / 0x0000_0C00 -> quotient=0x0000_0155 (truncated), remainder=0x0000_0400.
- Divide by zero: 0x0000_1400 / 0 -> ready 1 cycle after start, quotient=0x7FFF_FFFF, div_by_zero=1; 0xFFFF_EC00 / 0 -> 0x8000_0000.
- Overflow boundaries:
  - 0x7FFF_FFFF / 0x0000_0001 -> quotient=0x7FFF_FFFF, overflow=1.
  - 0x8000_0000 / 0x0000_0400 -> quotient=0x8000_0000, overflow=0.
  - 0x8000_0000 / 0xFFFF_FC00 -> quotient=0x7FFF_FFFF, overflow=1.
- Control:
  - Pulse start with new operands at cycle 10 of a busy division -> ignored; original result correct.
  - Assert reset at cycle 20 of a division -> all outputs 0 immediately, state IDLE.
  - Back-to-back start on the ready cycle -> ready drops, second result correct.

Source files
------------

// File: rtl/fixed_point_divider.sv
// ---------------------------------------------------------------------------
// fixed_point_divider
//
// Sequential signed fixed-point divider for the fixed-point unit. It computes
// dividend / divisor in Q(WIDTH-FBITS).FBITS two's-complement format, the
// inverse of the FPU multiplier. The core is a radix-2 restoring divider that
// works on magnitudes and produces one quotient bit per clock. A final cycle
// then applies the sign, saturation and status flags.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        division request, sampled only while idle
//   dividend     signed fixed-point numerator (captured on the start edge)
//   divisor      signed fixed-point denominator (captured on the start edge)
//   quotient     signed fixed-point result, truncated toward zero, saturated
//   remainder    remainder of (|dividend| << FBITS) / |divisor|, sign of dividend
//   busy         high while a division is in progress
//   ready        result valid; held until the next accepted start
//   div_by_zero  last result came from a zero divisor
//   overflow     last quotient was saturated
//
// Timing: a start accepted at edge k gives ready after edge k+N+1, where
// N = WIDTH+FBITS. A zero divisor skips the iterations, so ready follows
// after edge k+1.
// ---------------------------------------------------------------------------
module fixed_point_divider #(
  parameter int WIDTH = 32,
  parameter int FBITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             ready,
  output logic             div_by_zero,
  output logic             overflow
);

  // N quotient bits are developed: the numerator is pre-scaled by 2^FBITS.
  localparam int N     = WIDTH + FBITS;
  localparam int CNT_W = $clog2(N);
  localparam int RW    = WIDTH + 1;   // partial remainder width
  localparam int TW    = WIDTH + 2;   // trial (shifted remainder) width

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

  // Largest magnitudes representable for positive and negative results.
  localparam logic [N-1:0] POS_LIMIT = {{(N-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [N-1:0] NEG_LIMIT = {{(N-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN
  } state_t;

  state_t            state_reg,       state_next;
  logic [CNT_W-1:0]  cnt_reg,         cnt_next;
  logic [N-1:0]      num_reg,         num_next;
  logic [N-1:0]      quo_reg,         quo_next;
  logic [RW-1:0]     rem_reg,         rem_next;
  logic [WIDTH-1:0]  dvsr_reg,        dvsr_next;
  logic              neg_dvd_reg,     neg_dvd_next;
  logic              neg_quo_reg,     neg_quo_next;
  logic              dz_pend_reg,     dz_pend_next;
  logic [WIDTH-1:0]  quotient_reg,    quotient_next;
  logic [WIDTH-1:0]  remainder_reg,   remainder_next;
  logic              busy_reg,        busy_next;
  logic              ready_reg,       ready_next;
  logic              div_by_zero_reg, div_by_zero_next;
  logic              overflow_reg,    overflow_next;

  // Operand magnitudes. The unsigned WIDTH-bit result of negating the most
  // negative value is exactly 2^(WIDTH-1), so no wrap can occur here.
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvsr_mag;

  assign dvd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvsr_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

  // Restoring step: bring down the next numerator bit, then do a trial subtract.
  logic [TW-1:0] trial;
  logic [TW-1:0] dvsr_ext;
  logic          trial_ge;

  assign trial    = {rem_reg, num_reg[N-1]};
  assign dvsr_ext = {2'b00, dvsr_reg};
  assign trial_ge = (trial >= dvsr_ext);

  // Saturation tests on the unsigned quotient magnitude.
  logic pos_ovf;
  logic neg_ovf;

  assign pos_ovf = (quo_reg > POS_LIMIT);
  assign neg_ovf = (quo_reg > NEG_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      num_reg         <= '0;
      quo_reg         <= '0;
      rem_reg         <= '0;
      dvsr_reg        <= '0;
      neg_dvd_reg     <= 1'b0;
      neg_quo_reg     <= 1'b0;
      dz_pend_reg     <= 1'b0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      busy_reg        <= 1'b0;
      ready_reg       <= 1'b0;
      div_by_zero_reg <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      num_reg         <= num_next;
      quo_reg         <= quo_next;
      rem_reg         <= rem_next;
      dvsr_reg        <= dvsr_next;
      neg_dvd_reg     <= neg_dvd_next;
      neg_quo_reg     <= neg_quo_next;
      dz_pend_reg     <= dz_pend_next;
      quotient_reg    <= quotient_next;
      remainder_reg   <= remainder_next;
      busy_reg        <= busy_next;
      ready_reg       <= ready_next;
      div_by_zero_reg <= div_by_zero_next;
      overflow_reg    <= overflow_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    num_next         = num_reg;
    quo_next         = quo_reg;
    rem_next         = rem_reg;
    dvsr_next        = dvsr_reg;
    neg_dvd_next     = neg_dvd_reg;
    neg_quo_next     = neg_quo_reg;
    dz_pend_next     = dz_pend_reg;
    quotient_next    = quotient_reg;
    remainder_next   = remainder_reg;
    busy_next        = busy_reg;
    ready_next       = ready_reg;
    div_by_zero_next = div_by_zero_reg;
    overflow_next    = overflow_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          neg_dvd_next     = dividend[WIDTH-1];
          neg_quo_next     = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          dvsr_next        = dvsr_mag;
          num_next         = {dvd_mag, {FBITS{1'b0}}};
          quo_next         = '0;
          rem_next         = '0;
          cnt_next         = '0;
          ready_next       = 1'b0;
          div_by_zero_next = 1'b0;
          overflow_next    = 1'b0;
          if (divisor == '0) begin
            // No iterations are needed; the result is fixed by the dividend sign.
            dz_pend_next = 1'b1;
            state_next   = SIGN;
          end else begin
            dz_pend_next = 1'b0;
            busy_next    = 1'b1;
            state_next   = CALC;
          end
        end
      end

      CALC: begin
        // The partial remainder stays below |divisor|, so whenever the
        // subtraction is skipped the trial value already fits in RW bits.
        if (trial_ge) begin
          rem_next = RW'(trial - dvsr_ext);
        end else begin
          rem_next = trial[RW-1:0];
        end
        quo_next = {quo_reg[N-2:0], trial_ge};
        num_next = {num_reg[N-2:0], 1'b0};
        if (cnt_reg == LAST_ITER) begin
          state_next = SIGN;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      SIGN: begin
        if (dz_pend_reg) begin
          quotient_next    = neg_dvd_reg ? MOST_NEG : MOST_POS;
          remainder_next   = '0;
          div_by_zero_next = 1'b1;
          overflow_next    = 1'b0;
        end else begin
          div_by_zero_next = 1'b0;
          if (!neg_quo_reg) begin
            overflow_next = pos_ovf;
            quotient_next = pos_ovf ? MOST_POS : quo_reg[WIDTH-1:0];
          end else begin
            // A magnitude of exactly 2^(WIDTH-1) negates cleanly to MOST_NEG.
            overflow_next = neg_ovf;
            quotient_next = neg_ovf ? MOST_NEG : -quo_reg[WIDTH-1:0];
          end
          remainder_next = neg_dvd_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
        end
        dz_pend_next = 1'b0;
        ready_next   = 1'b1;
        busy_next    = 1'b0;
        state_next   = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign busy        = busy_reg;
  assign ready       = ready_reg;
  assign div_by_zero = div_by_zero_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_fixed_point_divider.sv
// ---------------------------------------------------------------------------
// tb_fixed_point_divider
//
// Scoreboard bench for fixed_point_divider (WIDTH=32, FBITS=10). The driver
// pushes the expected result for each accepted division into a queue. A
// monitor pops one entry on every rising edge of ready and compares it. The
// reference model uses plain 64-bit integer division on magnitudes.
// ---------------------------------------------------------------------------
module tb_fixed_point_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        ready;
  logic        div_by_zero;
  logic        overflow;

  fixed_point_divider #(.WIDTH(32), .FBITS(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .ready       (ready),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   start_cyc = 0;
  int   lat;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endfunction

  // Reference model: signed fixed-point division with truncation toward zero,
  // saturation and divide-by-zero codes.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, ma, mb, num, qm, rm;
    bit     neg;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0;
    e.ov = 1'b0;
    if (sb == 0) begin
      e.dz = 1'b1;
      e.q  = (sa >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      e.r  = 32'h0;
      return e;
    end
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sb < 0) ? -sb : sb;
    num = ma * 1024;
    qm  = num / mb;
    rm  = num % mb;
    neg = (sa < 0) != (sb < 0);
    if (!neg) begin
      if (qm > 64'sd2147483647) begin
        e.q  = 32'h7FFF_FFFF;
        e.ov = 1'b1;
      end else begin
        e.q = 32'(qm);
      end
    end else begin
      if (qm > 64'sd2147483648) begin
        e.q  = 32'h8000_0000;
        e.ov = 1'b1;
      end else begin
        e.q = 32'(-qm);
      end
    end
    e.r = (sa < 0) ? 32'(-rm) : 32'(rm);
    return e;
  endfunction

  // Monitor: compare each new result against the scoreboard and check that
  // the outputs hold steady while ready stays high.
  logic        ready_prev = 1'b0;
  logic [31:0] held_q, held_r;

  always @(negedge clk) begin
    exp_t e;
    if (ready && !ready_prev) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got q=%h with empty scoreboard", quotient);
      end else begin
        e = exp_q.pop_front();
        $display("result a=%h b=%h q=%h r=%h dz=%0b ov=%0b", dividend, divisor, quotient, remainder, div_by_zero, overflow);
        chk("quotient", 64'(quotient), 64'(e.q));
        chk("remainder", 64'(remainder), 64'(e.r));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
        chk("overflow", 64'(overflow), 64'(e.ov));
      end
      held_q = quotient;
      held_r = remainder;
    end else if (ready && ready_prev) begin
      chk("hold", {quotient, remainder}, {held_q, held_r});
    end
    ready_prev = ready;
  end

  // Drive one start pulse. With sync=1 the task first waits for a falling
  // edge; with sync=0 it drives immediately.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit sync);
    if (sync) @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  task automatic wait_ready(output int l);
    l = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready) begin
        l = cyc - start_cyc;
        break;
      end
    end
    if (l < 0) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got no ready expected ready within 200 cycles");
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    int l;
    issue(a, b, 1'b1);
    wait_ready(l);
  endtask

  logic [31:0] ra, rb;
  int          sel;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("reset_q", 64'(quotient), 64'h0);
    chk("reset_r", 64'(remainder), 64'h0);
    chk("reset_flags", 64'({busy, ready, div_by_zero, overflow}), 64'h0);
    reset = 1'b0;

    // 6.0 / 2.0: latency and busy profile
    issue(32'h0000_1800, 32'h0000_0800, 1'b1);
    chk("busy_after_start", 64'(busy), 64'h1);
    wait_ready(lat);
    chk("latency_normal", 64'(lat), 64'd43);
    chk("busy_at_ready", 64'(busy), 64'h0);

    // Sign combinations and truncation
    run_op(32'hFFFF_E200, 32'h0000_0800);
    run_op(32'h0000_1E00, 32'hFFFF_F800);
    run_op(32'hFFFF_E200, 32'hFFFF_F800);
    run_op(32'h0000_0400, 32'h0000_0C00);
    run_op(32'h0000_0000, 32'hFFFF_F400);

    // Divide by zero
    issue(32'h0000_1400, 32'h0000_0000, 1'b1);
    wait_ready(lat);
    chk("latency_dz", 64'(lat), 64'd1);
    run_op(32'hFFFF_EC00, 32'h0000_0000);

    // Saturation boundaries
    run_op(32'h7FFF_FFFF, 32'h0000_0001);
    run_op(32'h8000_0000, 32'h0000_0400);
    run_op(32'h8000_0000, 32'hFFFF_FC00);

    // Start while busy is ignored
    issue(32'h0000_2400, 32'h0000_0C00, 1'b1);
    repeat (9) @(negedge clk);
    dividend = 32'h1111_1111;
    divisor  = 32'h0000_0003;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_ignore", 64'(busy), 64'h1);
    wait_ready(lat);
    chk("latency_ignore", 64'(lat), 64'd43);

    // Reset in the middle of a division
    issue(32'h0000_5000, 32'h0000_0300, 1'b1);
    repeat (19) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_q", 64'(quotient), 64'h0);
    chk("midreset_r", 64'(remainder), 64'h0);
    chk("midreset_flags", 64'({busy, ready, div_by_zero, overflow}), 64'h0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk("idle_after_reset", 64'({busy, ready}), 64'h0);

    // Back-to-back: new start on the first ready cycle
    run_op(32'h0000_0C00, 32'h0000_0400);
    issue(32'hFFFF_F000, 32'h0000_0600, 1'b0);
    chk("ready_drop", 64'(ready), 64'h0);
    wait_ready(lat);
    chk("latency_b2b", 64'(lat), 64'd43);

    // Randomized operands
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 5);
      ra  = $urandom;
      rb  = $urandom;
      case (sel)
        0: rb = 32'h0;
        1: ra = 32'h0;
        2: begin
          rb = $urandom_range(1, 32'h0000_FFFF);
          if ($urandom_range(0, 1) == 1) rb = -rb;
        end
        3: begin
          ra = $urandom_range(0, 32'h000F_FFFF);
          if ($urandom_range(0, 1) == 1) ra = -ra;
          rb = $urandom_range(1, 32'h0000_3FFF);
          if ($urandom_range(0, 1) == 1) rb = -rb;
        end
        default: ;
      endcase
      run_op(ra, rb);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
